mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states added to each data-memory access (legal range 0..15).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single system clock (rising edge).
REQ-003 The block SHALL have port rst, input, 1 bit, meaning reset: asynchronous, active-low.
REQ-004 The block SHALL have inputs WB_EN_in, MEM_R_EN_in and MEM_W_EN_in, 1 bit each, meaning the EX-stage writeback, load and store controls.
REQ-005 The block SHALL have inputs ALU_Res_in (8 bits, address or passthrough result), Val_Rm_in (8 bits, store data) and Dest_in (2 bits, destination register).
REQ-006 The block SHALL have outputs WB_EN, MEM_R_EN, Val_LDR[7:0], ALU_Res[7:0] and Dest[1:0], meaning the values fed to the MEM/WB register.
REQ-007 The block SHALL have output freeze, 1 bit, meaning stall request; while it is high, upstream stages hold their state.
REQ-008 The block SHALL have output stall_cnt, 16 bits, meaning the count of freeze cycles (see Configuration).

Function
REQ-009 The block SHALL contain a 256x8 data memory indexed by ALU_Res_in; memory contents SHALL NOT be cleared by reset.
REQ-010 An access SHALL be MEM_R_EN_in=1 or MEM_W_EN_in=1; if both are high, the access SHALL be a store and MEM_R_EN out SHALL be 0.
REQ-011 A non-access instruction SHALL pass all fields to the outputs combinationally in the same cycle, with freeze=0 and Val_LDR=0.
REQ-012 The FSM states SHALL be IDLE and BUSY; the block SHALL reset to IDLE.
REQ-013 In IDLE, when an access arrives and WAIT_CYCLES>0, the block SHALL latch address, store data, Dest, WB_EN and the controls, load a counter with WAIT_CYCLES-1, and go to BUSY.
REQ-014 freeze SHALL be high in the arrival cycle and in every BUSY cycle with counter!=0, giving exactly WAIT_CYCLES freeze cycles per access.
REQ-015 While freeze is high, the outputs SHALL present a bubble: WB_EN=0, MEM_R_EN=0, Val_LDR=0, ALU_Res=0, Dest=0.
REQ-016 In the BUSY cycle with counter==0 (completion), freeze SHALL be 0 and the outputs SHALL carry the latched fields; a load SHALL drive Val_LDR=mem[latched address].
REQ-017 A store SHALL write mem[latched address] at the clock edge ending the completion cycle, and SHALL drive Val_LDR=0 in that cycle.
REQ-018 The FSM SHALL return to IDLE after completion; total access latency SHALL be WAIT_CYCLES+1 cycles.
REQ-019 With WAIT_CYCLES=0, accesses SHALL complete in the arrival cycle: no BUSY state, freeze=0, a load reads combinationally, and a store writes at that cycle's edge.
REQ-020 Inputs arriving during BUSY SHALL be ignored; upstream holds them under freeze.
REQ-021 An access arriving in the cycle after a completion SHALL start a new access with no idle gap.

Reset
REQ-022 When rst=0, the block SHALL force state=IDLE, counter=0 and all latched fields to 0, so outputs show a bubble and freeze=0; stall_cnt SHALL be 0.
REQ-023 A reset during BUSY SHALL abort the access; a pending store SHALL NOT be written.
REQ-024 On rst deassertion, operation SHALL resume at the first rising clk edge.

Configuration
REQ-025 The macro MEM_PERF_EN SHALL control stall counting: when it is defined, stall_cnt SHALL increment once per cycle with freeze=1 and saturate at 0xFFFF.
REQ-026 When MEM_PERF_EN is undefined, stall_cnt SHALL be a constant 0, no counter logic SHALL be built, and all other behaviour SHALL be unchanged.

Verification
REQ-027 The bench SHALL cover this case: WAIT_CYCLES=2, store Val_Rm=0x5A to address 0x10 -> freeze high 2 cycles with bubble outputs, then completion with WB_EN=0, and mem[0x10]=0x5A afterward.
REQ-028 The bench SHALL cover this case: a load from 0x10 with Dest=2, WB_EN=1 -> 2 freeze cycles, then Val_LDR=0x5A, MEM_R_EN=1, Dest=2, ALU_Res=0x10.
REQ-029 The bench SHALL cover this case: ALU op with ALU_Res=0x33, WB_EN=1 -> same-cycle passthrough, freeze=0, Val_LDR=0.
REQ-030 The bench SHALL cover this case: store of 0xFF to 0x20 with rst pulled low in the second freeze cycle -> state IDLE, freeze=0, mem[0x20] unchanged.
REQ-031 The bench SHALL cover this case: both R and W enables high, data 0x77 to address 0x01 -> store performed and MEM_R_EN out=0.
REQ-032 The bench SHALL cover this case: with MEM_PERF_EN defined, three back-to-back loads -> stall_cnt=6; with MEM_PERF_EN undefined -> stall_cnt=0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: 256x8 data memory with WAIT_CYCLES wait states per access.
// Optional stall counter built only when MEM_PERF_EN is defined.
module mem_stage #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [7:0]  ALU_Res_in,
  input  logic [7:0]  Val_Rm_in,
  input  logic [1:0]  Dest_in,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [7:0]  Val_LDR,
  output logic [7:0]  ALU_Res,
  output logic [1:0]  Dest,
  output logic        freeze,
  output logic [15:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic       wb;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] dest;
  } req_t;

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [7:0] mem [256];

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       lat_q, lat_d;
  req_t       in_req, cur;
  logic       access, pass, done, mem_we;

  // A store wins over a load when both enables are high.
  assign access = MEM_R_EN_in | MEM_W_EN_in;
  assign in_req = '{wb:   WB_EN_in,
                    rd:   MEM_R_EN_in & ~MEM_W_EN_in,
                    wr:   MEM_W_EN_in,
                    addr: ALU_Res_in,
                    data: Val_Rm_in,
                    dest: Dest_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    cur     = in_req;
    freeze  = 1'b0;
    pass    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!access) begin
          pass = 1'b1;
        end else if (ZERO_WAIT) begin
          done = 1'b1;
        end else begin
          freeze  = 1'b1;
          lat_d   = in_req;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cur = lat_q;
        if (cnt_q != 4'd0) begin
          freeze = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Held reset shows a bubble and suppresses any write, even for a zero-wait access.
    if (!rst) begin
      freeze = 1'b0;
      pass   = 1'b0;
      done   = 1'b0;
    end
  end

  always_comb begin
    WB_EN    = 1'b0;
    MEM_R_EN = 1'b0;
    Val_LDR  = 8'h00;
    ALU_Res  = 8'h00;
    Dest     = 2'd0;
    if (pass || done) begin
      WB_EN    = cur.wb;
      MEM_R_EN = cur.rd;
      ALU_Res  = cur.addr;
      Dest     = cur.dest;
      if (done && cur.rd) Val_LDR = mem[cur.addr];
    end
  end

  assign mem_we = done & cur.wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur.addr] <= cur.data;
  end

`ifdef MEM_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            stall_q <= 16'd0;
    else if (freeze && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
